memory_arbiter: RTL and testbench
=================================

# memory_arbiter

Shares the single core-side memory port between the fetch stage's instruction requests (imem) and the decode stage's data requests (dmem: load, store, fence). It accepts one-cycle request pulses from both requesters and queues at most one request per requester. It issues one transaction at a time downstream and routes each `mem_ready`/`mem_rdata` response back to the requester that owns it. It sits between the fetch/decode stages and the memory/bus fabric.

## Interface
- No parameters. All fields of `mem_in_type` are `mem_valid`, `mem_fence`, `mem_spec`, `mem_instr`, `mem_addr[31:0]`, `mem_wdata[31:0]` and `mem_wstrb[3:0]`. All fields of `mem_out_type` are `mem_ready` and `mem_rdata[31:0]`.
- reset  in  1  synchronous, active-low
- clock  in  1  rising-edge clock
- imem_in  in  mem_in_type  fetch request; `mem_valid` is a one-cycle pulse
- imem_out  out  mem_out_type  fetch response
- dmem_in  in  mem_in_type  decode-stage request; `mem_valid` is a one-cycle pulse
- dmem_out  out  mem_out_type  data response
- mem_in  out  mem_in_type  downstream request; `mem_valid` is a one-cycle pulse
- mem_out  in  mem_out_type  downstream response; `mem_ready` is a one-cycle pulse, asserted no earlier than 1 cycle after the matching `mem_valid`

## Operation
- **State register.** `state` ∈ {IDLE, BUSY_I, BUSY_D}.
- **Holding buffers.** Two one-deep buffers, `ibuf` and `dbuf`, each holding a full `mem_in_type` plus a pending bit.
- **Fairness register.** 1-bit `last`, which records the port granted most recently.
- **Capture.** An incoming request pulse that is not issued in its arrival cycle is written into its port's buffer.
- **Candidates.** In IDLE, a port's candidate is its pending buffer if the pending bit is set; otherwise it is its live input pulse. A pending buffer always takes precedence over the live input of the same port.
- **Arbitration (IDLE only).**
  - If exactly one port has a candidate, that port is granted.
  - If both ports have candidates, the port not equal to `last` is granted.
  - `last` resets to imem, so dmem wins the first tie.
- **Grant actions.**
  - The grant drives the candidate onto `mem_in` with `mem_valid`=1 in the same cycle (zero-cycle bypass).
  - `mem_instr` is forced to 1 for imem grants and 0 for dmem grants. All other fields pass through unchanged.
  - State moves to BUSY_I or BUSY_D, `last` updates, and the granted buffer's pending bit is cleared.
- **BUSY states.**
  - `mem_in.mem_valid`=0.
  - On `mem_out.mem_ready`=1, the owner's `*_out.mem_ready` is pulsed and `mem_out.mem_rdata` is passed through combinationally. State returns to IDLE.
  - The non-owner's `*_out` stays 0.
  - Pending requests are issued no earlier than the IDLE cycle that follows.
- **Fence.** A dmem request with `mem_fence`=1 is a normal transaction, completed by `mem_ready`.
- **Requester protocol.**
  - Each requester has at most one request outstanding (buffered or in flight). It may issue its next request in the same cycle it receives `mem_ready`; that request is captured into its buffer.
  - A pulse arriving while its port's buffer is already pending is a protocol violation. The arbiter ignores it and leaves the buffer unchanged.
- **`mem_out.mem_ready` while IDLE.** Ignored; no response is routed.
- **Reset (synchronous, active-low).**
  - Registers: `state`=IDLE, both pending bits=0, `last`=imem.
  - Outputs while `reset`=0: `mem_in` all fields 0, `imem_out` and `dmem_out` all fields 0.
  - An in-flight downstream transaction is abandoned; its late `mem_ready` arrives while IDLE and is ignored.

## Timing
- **Uncontended latency.** Request at cycle t in IDLE gives `mem_in.mem_valid` at t. Downstream `mem_ready` at t+k (k≥1) gives the requester's `mem_ready` at t+k.
- **Turnaround.** One bubble cycle: the next pending transaction issues at t+k+1 at the earliest.
- **Losing request.** A request losing arbiter at cycle t issues at t'+1, where t' is the `mem_ready` cycle of the winner.
- **Registered paths.** Only `state`, the buffers and `last` are registered.
- **Combinational paths.** `mem_in` (bypass path), and `imem_out`/`dmem_out` from `mem_out`.

## Test plan
- **Single imem fetch.** Stimulus: `imem_in` valid, addr 0x100, at cycle 2; `mem_ready` with rdata 0x00000013 at cycle 4. Required response: `mem_in` valid at cycle 2 with `mem_instr`=1; `imem_out.mem_ready`=1 with rdata 0x00000013 at cycle 4; `dmem_out` stays 0 throughout.
- **Simultaneous requests after reset.** Stimulus: imem 0x200 and dmem load 0x8000 at cycle 1; each transaction completes 2 cycles after issue. Required response: dmem issued at cycle 1; `dmem_out.mem_ready` at cycle 3; imem issued from `ibuf` at cycle 4; `imem_out.mem_ready` at cycle 6.
- **Fairness.** Stimulus: both ports keep one request pending continuously. Required response: grants alternate D, I, D, I; neither port is granted twice in a row.
- **Store passthrough.** Stimulus: dmem store, addr 0x10, wdata 0xDEADBEEF, wstrb 0xF. Required response: `mem_in` carries identical fields with `mem_instr`=0. Then a fence request (`mem_fence`=1): it completes and routes `mem_ready` to `dmem_out`.
- **Back-to-back on one port.** Stimulus: imem requests a new fetch in the same cycle its `mem_ready` arrives (cycle 5). Required response: the new fetch is captured into `ibuf` and issued at cycle 6.
- **Reset mid-transaction.** Stimulus: `reset`=0 at cycle 3 while BUSY_D with `ibuf` pending; stray `mem_ready` at cycle 5 after reset is released. Required response: all outputs 0 during reset; the stray `mem_ready` is not routed to either requester; the next imem request issues in the cycle it arrives.

Source files
------------

// File: rtl/memory_arbiter.sv
// memory_arbiter: shares one downstream memory port between fetch (imem) and
// decode (dmem) requesters, one transaction in flight, one buffered request per port.

package memory_arbiter_pkg;

  typedef struct packed {
    logic        mem_valid;
    logic        mem_fence;
    logic        mem_spec;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
  } mem_in_type;

  typedef struct packed {
    logic        mem_ready;
    logic [31:0] mem_rdata;
  } mem_out_type;

endpackage

module memory_arbiter
  import memory_arbiter_pkg::*;
(
  input  logic        reset,
  input  logic        clock,
  input  mem_in_type  imem_in,
  output mem_out_type imem_out,
  input  mem_in_type  dmem_in,
  output mem_out_type dmem_out,
  output mem_in_type  mem_in,
  input  mem_out_type mem_out
);

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] BUSY_I = 2'b01;
  localparam logic [1:0] BUSY_D = 2'b10;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  logic [1:0] state_q, state_d;
  mem_in_type ibuf_q,  ibuf_d;
  mem_in_type dbuf_q,  dbuf_d;
  logic       ipend_q, ipend_d;
  logic       dpend_q, dpend_d;
  logic       last_q,  last_d;

  mem_in_type icand, dcand;
  logic       icand_v, dcand_v;
  logic       grant_i, grant_d;

  // Per-port candidate (buffer beats live pulse) and round-robin grant in IDLE.
  always_comb begin
    icand   = ipend_q ? ibuf_q : imem_in;
    dcand   = dpend_q ? dbuf_q : dmem_in;
    icand_v = ipend_q | imem_in.mem_valid;
    dcand_v = dpend_q | dmem_in.mem_valid;
    grant_d = (state_q == IDLE) && dcand_v && (!icand_v || (last_q == PORT_I));
    grant_i = (state_q == IDLE) && icand_v && !grant_d;
  end

  // Next-state, buffer capture and combinational issue/response routing.
  always_comb begin
    state_d  = state_q;
    ibuf_d   = ibuf_q;
    dbuf_d   = dbuf_q;
    ipend_d  = ipend_q;
    dpend_d  = dpend_q;
    last_d   = last_q;
    mem_in   = '0;
    imem_out = '0;
    dmem_out = '0;

    case (state_q)
      IDLE: begin
        if (grant_i) begin
          mem_in           = icand;
          mem_in.mem_valid = 1'b1;
          mem_in.mem_instr = 1'b1;
          state_d          = BUSY_I;
          last_d           = PORT_I;
          ipend_d          = 1'b0;
        end else if (grant_d) begin
          mem_in           = dcand;
          mem_in.mem_valid = 1'b1;
          mem_in.mem_instr = 1'b0;
          state_d          = BUSY_D;
          last_d           = PORT_D;
          dpend_d          = 1'b0;
        end
      end
      BUSY_I: begin
        if (mem_out.mem_ready) begin
          imem_out = mem_out;
          state_d  = IDLE;
        end
      end
      BUSY_D: begin
        if (mem_out.mem_ready) begin
          dmem_out = mem_out;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A live pulse not issued this cycle is buffered; a pulse onto a full buffer is dropped.
    if (imem_in.mem_valid && !ipend_q && !grant_i) begin
      ibuf_d  = imem_in;
      ipend_d = 1'b1;
    end
    if (dmem_in.mem_valid && !dpend_q && !grant_d) begin
      dbuf_d  = dmem_in;
      dpend_d = 1'b1;
    end

    // Outputs are quiet while reset is held.
    if (!reset) begin
      mem_in   = '0;
      imem_out = '0;
      dmem_out = '0;
    end
  end

  // State, buffers and fairness register with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      ibuf_q  <= '0;
      dbuf_q  <= '0;
      ipend_q <= 1'b0;
      dpend_q <= 1'b0;
      last_q  <= PORT_I;
    end else begin
      state_q <= state_d;
      ibuf_q  <= ibuf_d;
      dbuf_q  <= dbuf_d;
      ipend_q <= ipend_d;
      dpend_q <= dpend_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed testbench for memory_arbiter with hand-computed expectations.

module tb_memory_arbiter;
  import memory_arbiter_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  mem_in_type  imem_in, dmem_in, mem_in;
  mem_out_type imem_out, dmem_out, mem_out;

  int n_tests = 0;
  int n_fail  = 0;

  memory_arbiter dut (
    .reset    (reset),
    .clock    (clock),
    .imem_in  (imem_in),
    .imem_out (imem_out),
    .dmem_in  (dmem_in),
    .dmem_out (dmem_out),
    .mem_in   (mem_in),
    .mem_out  (mem_out)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic mem_in_type req(input logic fence, input logic spec, input logic instr,
                                     input logic [31:0] addr, input logic [31:0] wdata,
                                     input logic [3:0] wstrb);
    mem_in_type r;
    r.mem_valid = 1'b1;
    r.mem_fence = fence;
    r.mem_spec  = spec;
    r.mem_instr = instr;
    r.mem_addr  = addr;
    r.mem_wdata = wdata;
    r.mem_wstrb = wstrb;
    return r;
  endfunction

  function automatic mem_in_type frc(input mem_in_type r, input logic instr);
    mem_in_type o;
    o = r;
    o.mem_instr = instr;
    return o;
  endfunction

  function automatic mem_out_type resp(input logic [31:0] d);
    mem_out_type o;
    o.mem_ready = 1'b1;
    o.mem_rdata = d;
    return o;
  endfunction

  // Advance one cycle; single-cycle pulses drop back to zero.
  task automatic tick();
    @(posedge clock);
    #1;
    imem_in = '0;
    dmem_in = '0;
    mem_out = '0;
  endtask

  task automatic settle();
    @(negedge clock);
  endtask

  // Leaves the bench at the start of cycle 0 with registers reset.
  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog timeout");
  end

  initial begin
    mem_in_type r, a, b, s, f, ci, cd;
    logic win_d;
    imem_in = '0;
    dmem_in = '0;
    mem_out = '0;
    reset   = 1'b0;

    // Single imem fetch
    do_reset();
    for (int c = 0; c < 2; c++) begin
      settle();
      check("s1_idle_mem_in", 72'(mem_in), 72'(0));
      tick();
    end
    r = req(1'b0, 1'b0, 1'b0, 32'h100, 32'h0, 4'h0);
    imem_in = r;
    settle();
    check("s1_issue", 72'(mem_in), 72'(frc(r, 1'b1)));
    check("s1_dmem_out_c2", 72'(dmem_out), 72'(0));
    tick();
    settle();
    check("s1_busy_mem_in", 72'(mem_in), 72'(0));
    check("s1_imem_out_c3", 72'(imem_out), 72'(0));
    tick();
    mem_out = resp(32'h00000013);
    settle();
    check("s1_imem_resp", 72'(imem_out), 72'(resp(32'h00000013)));
    check("s1_dmem_out_c4", 72'(dmem_out), 72'(0));
    tick();

    // Simultaneous requests after reset: dmem wins first tie
    do_reset();
    tick();
    a = req(1'b0, 1'b0, 1'b0, 32'h200, 32'h0, 4'h0);
    b = req(1'b0, 1'b0, 1'b1, 32'h8000, 32'h0, 4'h0);
    imem_in = a;
    dmem_in = b;
    settle();
    check("s2_dmem_issue", 72'(mem_in), 72'(frc(b, 1'b0)));
    tick();
    settle();
    check("s2_busy_c2", 72'(mem_in), 72'(0));
    tick();
    mem_out = resp(32'h0000000A);
    settle();
    check("s2_dmem_resp", 72'(dmem_out), 72'(resp(32'h0000000A)));
    check("s2_imem_quiet", 72'(imem_out), 72'(0));
    tick();
    settle();
    check("s2_imem_issue", 72'(mem_in), 72'(frc(a, 1'b1)));
    tick();
    tick();
    mem_out = resp(32'h0000000B);
    settle();
    check("s2_imem_resp", 72'(imem_out), 72'(resp(32'h0000000B)));
    tick();

    // Fairness: both ports keep a request pending, grants alternate D,I,D,I
    ci = req(1'b0, 1'b0, 1'b0, 32'h300, 32'h0, 4'h0);
    cd = req(1'b0, 1'b0, 1'b0, 32'h9000, 32'h0, 4'h0);
    imem_in = ci;
    dmem_in = cd;
    settle();
    check("fair_g0_d", 72'(mem_in), 72'(frc(cd, 1'b0)));
    tick();
    win_d = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      mem_out = resp(32'(k));
      if (win_d) begin
        cd.mem_addr = cd.mem_addr + 32'd4;
        dmem_in = cd;
      end else begin
        ci.mem_addr = ci.mem_addr + 32'd4;
        imem_in = ci;
      end
      settle();
      check("fair_resp", win_d ? 72'(dmem_out) : 72'(imem_out), 72'(resp(32'(k))));
      tick();
      win_d = !win_d;
      settle();
      check("fair_grant", 72'(mem_in), win_d ? 72'(frc(cd, 1'b0)) : 72'(frc(ci, 1'b1)));
      tick();
    end
    mem_out = resp(32'h4);
    settle();
    check("fair_last_i_resp", 72'(imem_out), 72'(resp(32'h4)));
    tick();
    settle();
    check("fair_drain_d", 72'(mem_in), 72'(frc(cd, 1'b0)));
    tick();
    mem_out = resp(32'h5);
    settle();
    check("fair_drain_resp", 72'(dmem_out), 72'(resp(32'h5)));
    tick();

    // Store passthrough, then fence
    s = req(1'b0, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    dmem_in = s;
    settle();
    check("st_issue", 72'(mem_in), 72'(frc(s, 1'b0)));
    tick();
    mem_out = resp(32'h55);
    settle();
    check("st_resp", 72'(dmem_out), 72'(resp(32'h55)));
    tick();
    f = req(1'b1, 1'b0, 1'b0, 32'h20, 32'h0, 4'h0);
    dmem_in = f;
    settle();
    check("fence_issue", 72'(mem_in), 72'(frc(f, 1'b0)));
    tick();
    settle();
    check("fence_busy", 72'(mem_in), 72'(0));
    tick();
    mem_out = resp(32'h66);
    settle();
    check("fence_resp", 72'(dmem_out), 72'(resp(32'h66)));
    check("fence_imem_quiet", 72'(imem_out), 72'(0));
    tick();

    // Back-to-back on imem: new fetch in the ready cycle issues next cycle
    do_reset();
    tick();
    tick();
    tick();
    a = req(1'b0, 1'b0, 1'b1, 32'h400, 32'h0, 4'h0);
    imem_in = a;
    settle();
    check("b2b_issue1", 72'(mem_in), 72'(frc(a, 1'b1)));
    tick();
    tick();
    mem_out = resp(32'h77);
    b = req(1'b0, 1'b0, 1'b0, 32'h404, 32'h0, 4'h0);
    imem_in = b;
    settle();
    check("b2b_resp1", 72'(imem_out), 72'(resp(32'h77)));
    check("b2b_no_bypass_busy", 72'(mem_in), 72'(0));
    tick();
    settle();
    check("b2b_issue2", 72'(mem_in), 72'(frc(b, 1'b1)));
    tick();
    mem_out = resp(32'h78);
    settle();
    check("b2b_resp2", 72'(imem_out), 72'(resp(32'h78)));
    tick();

    // Reset mid-transaction with ibuf pending
    do_reset();
    tick();
    b = req(1'b0, 1'b0, 1'b0, 32'h8100, 32'h0, 4'h0);
    dmem_in = b;
    settle();
    check("rst_d_issue", 72'(mem_in), 72'(frc(b, 1'b0)));
    tick();
    imem_in = req(1'b0, 1'b0, 1'b0, 32'h500, 32'h0, 4'h0);
    settle();
    check("rst_i_captured", 72'(mem_in), 72'(0));
    tick();
    for (int c = 0; c < 2; c++) begin
      reset   = 1'b0;
      mem_out = resp(32'h99);
      imem_in = req(1'b0, 1'b0, 1'b0, 32'h510, 32'h0, 4'h0);
      settle();
      check("rst_mem_in_zero", 72'(mem_in), 72'(0));
      check("rst_imem_out_zero", 72'(imem_out), 72'(0));
      check("rst_dmem_out_zero", 72'(dmem_out), 72'(0));
      tick();
    end
    reset   = 1'b1;
    mem_out = resp(32'hAA);
    settle();
    check("rst_stray_imem", 72'(imem_out), 72'(0));
    check("rst_stray_dmem", 72'(dmem_out), 72'(0));
    check("rst_ibuf_cleared", 72'(mem_in), 72'(0));
    tick();
    a = req(1'b0, 1'b0, 1'b0, 32'h600, 32'h0, 4'h0);
    imem_in = a;
    settle();
    check("rst_next_issue", 72'(mem_in), 72'(frc(a, 1'b1)));
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
